// File: rtl/spi_fdc_host_if.sv
// Host-side request/response bundle for spi_fdc_host.
// Handshake: a request transfers on a cycle with cmd_valid & cmd_ready; rsp_valid is a one-cycle pulse qualified by rsp_err.
interface spi_fdc_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
  );
endinterface

// File: rtl/spi_fdc_host.sv
// Clock-divided SPI mode-0 master issuing one ss-framed byte command per request to the
// cartridge SPI bridge, while shadowing the bridge's auto-incrementing address and bus ownership.
module spi_fdc_host #(
    parameter int CLKDIV = 4,
    parameter int GAP    = 8
) (
    input  logic        clock_50,
    input  logic        reset,
    spi_fdc_host_if.slave host,
    output logic [15:0] shadow_addr,
    output logic        bus_owned,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss
);

    localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam int GW = $clog2(GAP);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [GW-1:0] GAP_PRE  = GW'(GAP - 2);

    localparam logic [2:0] OP_SETADDR = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_ACQUIRE = 3'd3;
    localparam logic [2:0] OP_RELEASE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_BYTEGAP = 3'd3,
        ST_END     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [1:0]    last_byte_q, last_byte_d;
    logic [2:0]    op_q, op_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic          sclk_q, sclk_d;
    logic          ss_q, ss_d;
    logic          mosi_q, mosi_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          owned_q, owned_d;

    logic [7:0]    cur_byte;
    logic [7:0]    next_byte;
    logic [7:0]    first_byte;

    // Byte idx of the frame for an op; byte 0 is always the opcode (op + 1).
    function automatic logic [7:0] tx_byte(input logic [2:0] op, input logic [15:0] addr,
                                           input logic [7:0] wdata, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 2'd0) begin
            b = {5'd0, op + 3'd1};
        end else begin
            case (op)
                OP_SETADDR: b = (idx == 2'd1) ? addr[15:8] : addr[7:0];
                OP_WRITE:   b = wdata;
                default:    b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic logic [1:0] last_idx(input logic [2:0] op);
        logic [1:0] n;
        case (op)
            OP_SETADDR:        n = 2'd2;
            OP_WRITE, OP_READ: n = 2'd1;
            default:           n = 2'd0;
        endcase
        return n;
    endfunction

    assign cur_byte   = tx_byte(op_q, addr_q, wdata_q, byte_q);
    assign next_byte  = tx_byte(op_q, addr_q, wdata_q, byte_q + 2'd1);
    assign first_byte = tx_byte(host.cmd_op, host.cmd_addr, host.cmd_wdata, 2'd0);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        gap_d       = gap_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        last_byte_d = last_byte_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        shadow_d    = shadow_q;
        owned_d     = owned_q;

        case (state_q)
            ST_IDLE: begin
                if (host.cmd_valid) begin
                    op_d    = host.cmd_op;
                    addr_d  = host.cmd_addr;
                    wdata_d = host.cmd_wdata;
                    if (host.cmd_op <= OP_RELEASE) begin
                        state_d     = ST_SETUP;
                        ss_d        = 1'b0;
                        mosi_d      = first_byte[7];
                        div_d       = '0;
                        bit_d       = 3'd7;
                        byte_d      = 2'd0;
                        last_byte_d = last_idx(host.cmd_op);
                        rx_d        = 8'h00;
                    end else begin
                        // Invalid op: single END cycle carrying the error response.
                        state_d     = ST_END;
                        gap_d       = GAP_LAST;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 8'h00;
                    end
                end
            end

            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                // Slave drives miso on the falling edge; take it once sclk is seen high.
                if (sclk_q && div_q == '0) begin
                    rx_d = {rx_q[6:0], miso};
                end
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_BYTEGAP;
                            gap_d   = '0;
                        end else begin
                            bit_d  = bit_q - 3'd1;
                            mosi_d = cur_byte[bit_q - 3'd1];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_BYTEGAP: begin
                if (gap_q == GAP_LAST) begin
                    if (byte_q != last_byte_q) begin
                        state_d = ST_SHIFT;
                        byte_d  = byte_q + 2'd1;
                        bit_d   = 3'd7;
                        div_d   = '0;
                        mosi_d  = next_byte[7];
                    end else begin
                        state_d = ST_END;
                        gap_d   = '0;
                        ss_d    = 1'b1;
                        mosi_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_END: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                    // Response and shadow updates become visible together in the last END cycle.
                    if (gap_q == GAP_PRE) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = (op_q == OP_READ) ? rx_q : 8'h00;
                        case (op_q)
                            OP_SETADDR:        shadow_d = addr_q;
                            OP_WRITE, OP_READ: shadow_d = shadow_q + 16'd1;
                            OP_ACQUIRE:        owned_d  = 1'b1;
                            OP_RELEASE:        owned_d  = 1'b0;
                            default:           shadow_d = shadow_q;
                        endcase
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            gap_q       <= '0;
            bit_q       <= 3'd7;
            byte_q      <= 2'd0;
            last_byte_q <= 2'd0;
            op_q        <= 3'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rx_q        <= 8'h00;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            shadow_q    <= 16'h0000;
            owned_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            last_byte_q <= last_byte_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            shadow_q    <= shadow_d;
            owned_q     <= owned_d;
        end
    end

    assign host.cmd_ready = (state_q == ST_IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.dbg_state = state_q;
    assign shadow_addr    = shadow_q;
    assign bus_owned      = owned_q;
    assign sclk           = sclk_q;
    assign ss             = ss_q;
    assign mosi           = mosi_q;

endmodule

// File: tb/tb_spi_fdc_host.sv
// Directed bench for spi_fdc_host: SPI slave/monitor model, command driver, byte scoreboard.
module tb_spi_fdc_host;
  logic        clock_50;
  logic        reset;
  logic [15:0] shadow_addr;
  logic        bus_owned;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;

  spi_fdc_host_if host_if ();

  spi_fdc_host #(.CLKDIV(4), .GAP(8)) dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .host        (host_if),
    .shadow_addr (shadow_addr),
    .bus_owned   (bus_owned),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .ss          (ss)
  );

  // clock / reset
  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];

  // SPI slave model / monitor, evaluated on the falling clock edge
  logic [7:0] miso_pat = 8'h3C;
  logic [7:0] sh = 8'h00;
  int bit_cnt = 0;
  int fall_cnt = 0;
  int ss_falls = 0;
  int sclk_rises = 0;
  int mosi_viol = 0;
  logic sclk_prev = 1'b0;
  logic ss_prev = 1'b1;
  logic mosi_prev = 1'b0;

  always @(negedge clock_50) begin
    if (ss) begin
      bit_cnt = 0;
      fall_cnt = 0;
    end else begin
      if (sclk && !sclk_prev) begin
        sh = {sh[6:0], mosi};
        bit_cnt++;
        if (bit_cnt == 8) begin
          mon_q.push_back(sh);
          bit_cnt = 0;
        end
      end
      if (!sclk && sclk_prev) fall_cnt++;
    end
    if (sclk && sclk_prev && (mosi != mosi_prev)) mosi_viol++;
    if (!ss && ss_prev) ss_falls++;
    if (sclk && !sclk_prev) sclk_rises++;
    sclk_prev = sclk;
    ss_prev = ss;
    mosi_prev = mosi;
  end

  // Slave returns miso_pat MSB first during byte 1 of the frame.
  always_comb begin
    miso = 1'b0;
    if (!ss && fall_cnt >= 8 && fall_cnt < 16) miso = miso_pat[15 - fall_cnt];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Caller is at a falling edge; one request is issued and followed to its response.
  task automatic do_cmd(input string name, input logic [2:0] op, input logic [15:0] addr,
                        input logic [7:0] wdata, input int exp_lat, input logic [7:0] exp_rdata,
                        input logic exp_err);
    int lat;
    int falls0;
    int rises0;
    int nb;
    mon_q.delete();
    falls0 = ss_falls;
    rises0 = sclk_rises;
    check({name, " cmd_ready before"}, {31'd0, host_if.cmd_ready}, 32'd1);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = addr;
    host_if.cmd_wdata = wdata;
    @(negedge clock_50);
    host_if.cmd_valid = 1'b0;
    lat = 1;
    check({name, " ss at A+1"}, {31'd0, ss}, exp_err ? 32'd1 : 32'd0);
    while (!host_if.rsp_valid && lat < 1000) begin
      @(negedge clock_50);
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " rsp_rdata"}, {24'd0, host_if.rsp_rdata}, {24'd0, exp_rdata});
    check({name, " rsp_err"}, {31'd0, host_if.rsp_err}, {31'd0, exp_err});
    check({name, " ss at rsp"}, {31'd0, ss}, 32'd1);
    @(negedge clock_50);
    check({name, " rsp_valid one cycle"}, {31'd0, host_if.rsp_valid}, 32'd0);
    check({name, " cmd_ready after"}, {31'd0, host_if.cmd_ready}, 32'd1);
    check({name, " ss frames"}, ss_falls - falls0, exp_err ? 32'd0 : 32'd1);
    if (exp_err) check({name, " sclk edges"}, sclk_rises - rises0, 32'd0);
    nb = exp_q.size();
    check({name, " byte count"}, mon_q.size(), nb);
    for (int i = 0; i < nb; i++) begin
      if (i < mon_q.size())
        check($sformatf("%s byte %0d", name, i), {24'd0, mon_q[i]}, {24'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    int rsp_seen;
    reset = 1'b1;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
    host_if.cmd_addr  = 16'h0000;
    host_if.cmd_wdata = 8'h00;
    repeat (3) @(negedge clock_50);
    check("rst sclk", {31'd0, sclk}, 32'd0);
    check("rst ss", {31'd0, ss}, 32'd1);
    check("rst mosi", {31'd0, mosi}, 32'd0);
    check("rst rsp_valid", {31'd0, host_if.rsp_valid}, 32'd0);
    check("rst rsp_rdata", {24'd0, host_if.rsp_rdata}, 32'd0);
    check("rst rsp_err", {31'd0, host_if.rsp_err}, 32'd0);
    check("rst shadow_addr", {16'd0, shadow_addr}, 32'd0);
    check("rst bus_owned", {31'd0, bus_owned}, 32'd0);
    reset = 1'b0;
    @(negedge clock_50);
    check("rst cmd_ready", {31'd0, host_if.cmd_ready}, 32'd1);

    exp_q = '{8'h01, 8'h81, 8'h23};
    do_cmd("setaddr8123", 3'd0, 16'h8123, 8'h00, 228, 8'h00, 1'b0);
    check("shadow 8123", {16'd0, shadow_addr}, 32'h8123);

    exp_q = '{8'h04};
    do_cmd("acquire", 3'd3, 16'h0000, 8'h00, 84, 8'h00, 1'b0);
    check("owned after acquire", {31'd0, bus_owned}, 32'd1);

    exp_q = '{8'h02, 8'hA5};
    do_cmd("writeA5", 3'd1, 16'h0000, 8'hA5, 156, 8'h00, 1'b0);
    check("shadow 8124", {16'd0, shadow_addr}, 32'h8124);

    exp_q = '{8'h03, 8'h00};
    do_cmd("read", 3'd2, 16'h0000, 8'h00, 156, 8'h3C, 1'b0);
    check("shadow 8125", {16'd0, shadow_addr}, 32'h8125);
    check("rdata hold", {24'd0, host_if.rsp_rdata}, 32'h3C);

    exp_q = '{8'h01, 8'hFF, 8'hFF};
    do_cmd("setaddrFFFF", 3'd0, 16'hFFFF, 8'h00, 228, 8'h00, 1'b0);
    exp_q = '{8'h02, 8'h11};
    do_cmd("write11", 3'd1, 16'h0000, 8'h11, 156, 8'h00, 1'b0);
    check("shadow wrap", {16'd0, shadow_addr}, 32'h0000);

    exp_q = '{8'h01, 8'h12, 8'h34};
    do_cmd("setaddr1234", 3'd0, 16'h1234, 8'h00, 228, 8'h00, 1'b0);
    exp_q.delete();
    do_cmd("invalid6", 3'd6, 16'hBEEF, 8'h77, 1, 8'h00, 1'b1);
    check("invalid shadow", {16'd0, shadow_addr}, 32'h1234);
    check("invalid owned", {31'd0, bus_owned}, 32'd1);

    exp_q = '{8'h05};
    do_cmd("release", 3'd4, 16'h0000, 8'h00, 84, 8'h00, 1'b0);
    check("owned after release", {31'd0, bus_owned}, 32'd0);
    check("mosi stable while sclk high", mosi_viol, 32'd0);

    // Abort a WRITE with reset during bit 3 of its second byte.
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = 3'd1;
    host_if.cmd_wdata = 8'h5A;
    @(negedge clock_50);
    host_if.cmd_valid = 1'b0;
    cyc = 0;
    while (fall_cnt != 12 && cyc < 2000) begin
      @(negedge clock_50);
      cyc++;
    end
    check("reach bit3 of byte1", {31'd0, cyc < 2000}, 32'd1);
    @(negedge clock_50);
    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    check("abort ss", {31'd0, ss}, 32'd1);
    check("abort sclk", {31'd0, sclk}, 32'd0);
    check("abort shadow", {16'd0, shadow_addr}, 32'h0000);
    check("abort rsp_valid", {31'd0, host_if.rsp_valid}, 32'd0);
    rsp_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock_50);
      if (host_if.rsp_valid) rsp_seen++;
    end
    check("abort no rsp", rsp_seen, 32'd0);

    exp_q = '{8'h01, 8'h00, 8'hAB};
    do_cmd("setaddr00AB", 3'd0, 16'h00AB, 8'h00, 228, 8'h00, 1'b0);
    check("shadow 00AB", {16'd0, shadow_addr}, 32'h00AB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
